// File: rtl/vga_pkg.sv
// 640x480@60 timing defaults, derived totals and phase encodings shared by
// the VGA timing generator, its interface and its bench.
package vga_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_CLK_DIV   = 2;

  localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned CNT_W = 10;
  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {H_VIS, H_FP, H_SYNC, H_BP} h_phase_t;
  typedef enum logic [1:0] {V_VIS, V_FP, V_SYNC, V_BP} v_phase_t;

  // Modulo increment: wraps to zero after the given last value.
  function automatic count_t wrap_inc(input count_t c, input count_t last);
    return (c == last) ? '0 : c + count_t'(1);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle produced by vga_timing_gen; en flows from the consumer side.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic   en;
  logic   pix_tick;
  count_t hcount;
  count_t vcount;
  logic   hsync;
  logic   vsync;
  logic   video_on;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  en,
    output pix_tick, hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_tick, hcount, vcount, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider: pix_tick is high while the divider sits on its last
// count and the block is enabled (CLK_DIV legal range 1..16).
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pix_tick
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

  logic [3:0] div;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 4'd1;
    end
  end

  assign pix_tick = en & ~rst & (div == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, horizontal and vertical phase FSMs,
// registered syncs/video_on aligned with the counts, line/frame start pulses.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = vga_pkg::DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = vga_pkg::DEF_H_FRONT,
  parameter int unsigned H_SYNC      = vga_pkg::DEF_H_SYNC,
  parameter int unsigned H_BACK      = vga_pkg::DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = vga_pkg::DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = vga_pkg::DEF_V_FRONT,
  parameter int unsigned V_SYNC      = vga_pkg::DEF_V_SYNC,
  parameter int unsigned V_BACK      = vga_pkg::DEF_V_BACK,
  parameter int unsigned CLK_DIV     = vga_pkg::DEF_CLK_DIV,
  parameter bit          SYNC_ACTIVE = 1'b0
) (
  input logic             clk,
  input logic             rst,
  vga_timing_gen_if.master vif
);
  import vga_pkg::*;

  localparam count_t H_FP_AT = count_t'(H_VISIBLE);
  localparam count_t H_SY_AT = count_t'(H_VISIBLE + H_FRONT);
  localparam count_t H_BP_AT = count_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam count_t H_LAST  = count_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam count_t V_FP_AT = count_t'(V_VISIBLE);
  localparam count_t V_SY_AT = count_t'(V_VISIBLE + V_FRONT);
  localparam count_t V_BP_AT = count_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam count_t V_LAST  = count_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic     tick;
  count_t   hcount, vcount, h_nxt, v_nxt;
  logic     h_wrap, v_wrap;
  h_phase_t h_st, h_st_n;
  v_phase_t v_st, v_st_n;
  logic     hsync, vsync, video_on, ls_q, fs_q;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (vif.en),
    .pix_tick (tick)
  );

  // Next phases are decoded from the next counts so the registered syncs
  // and video_on land on the same edge as the counters.
  // H_SYNC/V_SYNC name both a width parameter and a phase; phases are qualified.
  always_comb begin
    h_wrap = (hcount == H_LAST);
    v_wrap = (vcount == V_LAST);
    h_nxt  = wrap_inc(hcount, H_LAST);
    v_nxt  = wrap_inc(vcount, V_LAST);
    h_st_n = h_st;
    v_st_n = v_st;
    if (tick) begin
      case (h_st)
        H_VIS:           if (h_nxt == H_FP_AT) h_st_n = H_FP;
        H_FP:            if (h_nxt == H_SY_AT) h_st_n = vga_pkg::H_SYNC;
        vga_pkg::H_SYNC: if (h_nxt == H_BP_AT) h_st_n = H_BP;
        H_BP:            if (h_wrap)           h_st_n = H_VIS;
        default:                               h_st_n = H_VIS;
      endcase
      if (h_wrap) begin
        case (v_st)
          V_VIS:           if (v_nxt == V_FP_AT) v_st_n = V_FP;
          V_FP:            if (v_nxt == V_SY_AT) v_st_n = vga_pkg::V_SYNC;
          vga_pkg::V_SYNC: if (v_nxt == V_BP_AT) v_st_n = V_BP;
          V_BP:            if (v_wrap)           v_st_n = V_VIS;
          default:                               v_st_n = V_VIS;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount   <= '0;
      vcount   <= '0;
      h_st     <= H_VIS;
      v_st     <= V_VIS;
      hsync    <= ~SYNC_ACTIVE;
      vsync    <= ~SYNC_ACTIVE;
      video_on <= 1'b1;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      ls_q <= tick & h_wrap;
      fs_q <= tick & h_wrap & v_wrap;
      if (tick) begin
        hcount <= h_nxt;
        if (h_wrap) vcount <= v_nxt;
      end
      h_st     <= h_st_n;
      v_st     <= v_st_n;
      hsync    <= (h_st_n == vga_pkg::H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync    <= (v_st_n == vga_pkg::V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_on <= (h_st_n == H_VIS) && (v_st_n == V_VIS);
    end
  end

  assign vif.pix_tick    = tick;
  assign vif.hcount      = hcount;
  assign vif.vcount      = vcount;
  assign vif.hsync       = hsync;
  assign vif.vsync       = vsync;
  assign vif.video_on    = video_on;
  // Pulses are suppressed while the raster is frozen.
  assign vif.line_start  = ls_q & vif.en;
  assign vif.frame_start = fs_q & vif.en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a default 640x480 instance for line-level behaviour and a
// shrunken 15x9 instance (active-high syncs) for frame-level behaviour.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef enum int unsigned {
    F_H, F_V, F_HS, F_VS, F_VON, F_LS, F_FS, F_TICK,
    F_HS_CNT, F_HS_FIRST, F_VON_CNT, F_VON_FIRST, F_VS_LINES, F_VS_FIRST, F_FRAME_LEN
  } fld_e;

  typedef struct {
    int unsigned at;
    int unsigned inst;
    fld_e        fld;
    int unsigned exp;
    string       name;
  } exp_t;

  localparam int unsigned R0    = 3;
  localparam bit          SA_A  = 1'b0;
  localparam bit          SA_B  = 1'b1;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int unsigned cyc = 0;
  int unsigned total = 0, bad = 0;
  bit done_a = 1'b0, done_b = 1'b0;

  exp_t sbq[$];
  int unsigned obs [2][16];
  int unsigned hs_cnt[2], hs_first[2], von_cnt[2], von_first[2];
  int unsigned vs_lines[2], vs_first[2], frame_cyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vga_timing_gen_if ia ();
  vga_timing_gen_if ib ();

  vga_timing_gen u_a (
    .clk (clk),
    .rst (rst_a),
    .vif (ia.master)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_ACTIVE(SA_B)
  ) u_b (
    .clk (clk),
    .rst (rst_b),
    .vif (ib.master)
  );

  function automatic void expect_at(input int unsigned at, input int unsigned inst,
                                    input fld_e f, input int unsigned v, input string nm);
    exp_t e;
    int idx;
    e.at = at; e.inst = inst; e.fld = f; e.exp = v; e.name = nm;
    idx = sbq.size();
    for (int i = 0; i < sbq.size(); i++) begin
      if (sbq[i].at > at) begin
        idx = i;
        break;
      end
    end
    sbq.insert(idx, e);
  endfunction

  function automatic void exp_pos(input int unsigned at, input int unsigned inst,
                                  input int unsigned h, input int unsigned v, input string nm);
    expect_at(at, inst, F_H, h, {nm, "_h"});
    expect_at(at, inst, F_V, v, {nm, "_v"});
  endfunction

  function automatic void exp_reset(input int unsigned at, input int unsigned inst,
                                    input int unsigned idle, input string nm);
    exp_pos(at, inst, 0, 0, nm);
    expect_at(at, inst, F_HS,   idle, {nm, "_hs"});
    expect_at(at, inst, F_VS,   idle, {nm, "_vs"});
    expect_at(at, inst, F_VON,  1,    {nm, "_von"});
    expect_at(at, inst, F_LS,   0,    {nm, "_ls"});
    expect_at(at, inst, F_FS,   0,    {nm, "_fs"});
    expect_at(at, inst, F_TICK, 0,    {nm, "_tick"});
  endfunction

  task automatic goto(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void update(input int unsigned i, input int unsigned h, input int unsigned v,
                                 input logic hs, input logic vs, input logic von,
                                 input logic ls, input logic fs, input logic tk);
    logic act;
    act = (i == 0) ? SA_A : SA_B;
    obs[i][F_H] = h;  obs[i][F_V] = v;
    obs[i][F_HS] = int'(hs); obs[i][F_VS] = int'(vs); obs[i][F_VON] = int'(von);
    obs[i][F_LS] = int'(ls); obs[i][F_FS] = int'(fs); obs[i][F_TICK] = int'(tk);
    frame_cyc[i]++;
    if (fs) begin
      obs[i][F_FRAME_LEN] = frame_cyc[i];
      frame_cyc[i] = 0;
    end
    if (ls) begin
      obs[i][F_HS_CNT] = hs_cnt[i];   obs[i][F_HS_FIRST] = hs_first[i];
      obs[i][F_VON_CNT] = von_cnt[i]; obs[i][F_VON_FIRST] = von_first[i];
      hs_cnt[i] = 0; hs_first[i] = 999; von_cnt[i] = 0; von_first[i] = 999;
      if (fs) begin
        obs[i][F_VS_LINES] = vs_lines[i]; obs[i][F_VS_FIRST] = vs_first[i];
        vs_lines[i] = 0; vs_first[i] = 999;
      end
      if (vs == act) begin
        if (vs_lines[i] == 0) vs_first[i] = v;
        vs_lines[i]++;
      end
    end
    if (tk) begin
      if (hs == act) begin
        if (hs_cnt[i] == 0) hs_first[i] = h;
        hs_cnt[i]++;
      end
      if (!von) begin
        if (von_cnt[i] == 0) von_first[i] = h;
        von_cnt[i]++;
      end
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    update(0, int'(ia.hcount), int'(ia.vcount), ia.hsync, ia.vsync, ia.video_on,
           ia.line_start, ia.frame_start, ia.pix_tick);
    update(1, int'(ib.hcount), int'(ib.vcount), ib.hsync, ib.vsync, ib.video_on,
           ib.line_start, ib.frame_start, ib.pix_tick);
    while (sbq.size() > 0 && sbq[0].at <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (e.at < cyc) begin
        bad++;
        $display("FAIL %s: actual=unchecked(cycle %0d) required=check at cycle %0d", e.name, cyc, e.at);
      end else if (obs[e.inst][e.fld] != e.exp) begin
        bad++;
        $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", e.name, obs[e.inst][e.fld], e.exp, cyc);
      end
    end
  end

  initial begin : stim_a
    int unsigned e_cyc, f_cyc;
    e_cyc = R0 + 19800;
    f_cyc = R0 + 20650;
    rst_a = 1'b1;
    ia.en = 1'b1;
    exp_reset(R0, 0, 1, "a_rst");
    goto(R0);
    rst_a = 1'b0;

    // Line wrap from (799,10) to (0,11), then the hsync/video_on shape of line 11.
    exp_pos  (R0 + 17598, 0, 799, 10, "a_prewrap");
    expect_at(R0 + 17598, 0, F_LS,   0, "a_prewrap_ls");
    expect_at(R0 + 17599, 0, F_TICK, 1, "a_wrap_tick");
    exp_pos  (R0 + 17600, 0, 0, 11, "a_wrap");
    expect_at(R0 + 17600, 0, F_LS,   1, "a_wrap_ls");
    expect_at(R0 + 17600, 0, F_FS,   0, "a_wrap_fs");
    expect_at(R0 + 17601, 0, F_LS,   0, "a_wrap_ls_end");
    expect_at(R0 + 18878, 0, F_VON,  1, "a_von_639");
    expect_at(R0 + 18880, 0, F_VON,  0, "a_von_640");
    expect_at(R0 + 18910, 0, F_HS,   1, "a_hs_655");
    expect_at(R0 + 18912, 0, F_HS,   0, "a_hs_656");
    expect_at(R0 + 19102, 0, F_HS,   0, "a_hs_751");
    expect_at(R0 + 19104, 0, F_HS,   1, "a_hs_752");
    expect_at(R0 + 19200, 0, F_HS_CNT,    96,  "a_hs_width");
    expect_at(R0 + 19200, 0, F_HS_FIRST,  656, "a_hs_first");
    expect_at(R0 + 19200, 0, F_VON_CNT,   160, "a_von_width");
    expect_at(R0 + 19200, 0, F_VON_FIRST, 640, "a_von_first");

    // Freeze at hcount=300 for 50 clocks.
    exp_pos  (e_cyc,      0, 300, 12, "a_en_at");
    expect_at(e_cyc + 1,  0, F_TICK, 0,   "a_en_tick1");
    expect_at(e_cyc + 25, 0, F_H,    300, "a_en_hold_h");
    expect_at(e_cyc + 25, 0, F_TICK, 0,   "a_en_hold_tick");
    expect_at(e_cyc + 25, 0, F_HS,   1,   "a_en_hold_hs");
    expect_at(e_cyc + 25, 0, F_VON,  1,   "a_en_hold_von");
    expect_at(e_cyc + 50, 0, F_H,    300, "a_en_last_h");
    expect_at(e_cyc + 51, 0, F_TICK, 1,   "a_en_resume_tick");
    expect_at(e_cyc + 51, 0, F_H,    300, "a_en_resume_h");
    expect_at(e_cyc + 52, 0, F_H,    301, "a_en_next_h");
    goto(e_cyc);
    ia.en = 1'b0;
    goto(e_cyc + 50);
    ia.en = 1'b1;

    // Reset during the hsync pulse at (700,12).
    exp_pos  (f_cyc, 0, 700, 12, "a_mid");
    expect_at(f_cyc, 0, F_HS,  0, "a_mid_hs");
    expect_at(f_cyc, 0, F_VON, 0, "a_mid_von");
    exp_reset(f_cyc + 1, 0, 1, "a_midrst");
    expect_at(f_cyc + 2, 0, F_TICK, 1, "a_first_tick");
    expect_at(f_cyc + 2, 0, F_H,    0, "a_first_tick_h");
    expect_at(f_cyc + 3, 0, F_H,    1, "a_first_step_h");
    goto(f_cyc);
    rst_a = 1'b1;
    goto(f_cyc + 1);
    rst_a = 1'b0;
    done_a = 1'b1;
  end

  initial begin : stim_b
    rst_b = 1'b1;
    ib.en = 1'b1;
    exp_reset(R0, 1, 0, "b_rst");
    goto(R0);
    rst_b = 1'b0;

    // 15-pixel lines: sync at h 10..12, visible h 0..7; 9-line frames: sync at v 6..7.
    exp_pos  (R0 + 48,  1, 9, 1, "b_h9");
    expect_at(R0 + 48,  1, F_HS,  0, "b_h9_hs");
    expect_at(R0 + 48,  1, F_VON, 0, "b_h9_von");
    expect_at(R0 + 50,  1, F_HS,  1, "b_h10_hs");
    expect_at(R0 + 56,  1, F_HS,  0, "b_h13_hs");
    exp_pos  (R0 + 60,  1, 0, 2, "b_line2");
    expect_at(R0 + 60,  1, F_LS,  1, "b_line2_ls");
    expect_at(R0 + 60,  1, F_HS_CNT,    3,  "b_hs_width");
    expect_at(R0 + 60,  1, F_HS_FIRST,  10, "b_hs_first");
    expect_at(R0 + 60,  1, F_VON_CNT,   7,  "b_von_width");
    expect_at(R0 + 60,  1, F_VON_FIRST, 8,  "b_von_first");
    exp_pos  (R0 + 104, 1, 7, 3, "b_lastvis");
    expect_at(R0 + 104, 1, F_VON, 1, "b_lastvis_von");
    expect_at(R0 + 120, 1, F_VON, 0, "b_v4_von");
    expect_at(R0 + 180, 1, F_VS,  1, "b_v6_vs");
    expect_at(R0 + 180, 1, F_HS,  0, "b_v6_hs");
    expect_at(R0 + 240, 1, F_VS,  0, "b_v8_vs");
    exp_pos  (R0 + 268, 1, 14, 8, "b_prewrap");
    exp_pos  (R0 + 270, 1, 0, 0, "b_fwrap");
    expect_at(R0 + 270, 1, F_FS,  1, "b_fwrap_fs");
    expect_at(R0 + 270, 1, F_LS,  1, "b_fwrap_ls");
    expect_at(R0 + 270, 1, F_VON, 1, "b_fwrap_von");
    expect_at(R0 + 270, 1, F_VS_LINES, 2, "b_vs_lines1");
    expect_at(R0 + 270, 1, F_VS_FIRST, 6, "b_vs_first1");
    expect_at(R0 + 271, 1, F_FS,  0, "b_fwrap_fs_end");
    expect_at(R0 + 271, 1, F_LS,  0, "b_fwrap_ls_end");
    expect_at(R0 + 540, 1, F_FS,  1, "b_frame2_fs");
    expect_at(R0 + 540, 1, F_FRAME_LEN, 270, "b_frame_len");
    expect_at(R0 + 540, 1, F_VS_LINES,  2,   "b_vs_lines2");

    // Reset in the middle of the vsync pulse at (11,7) of frame two.
    exp_pos  (R0 + 772, 1, 11, 7, "b_mid");
    expect_at(R0 + 772, 1, F_HS, 1, "b_mid_hs");
    expect_at(R0 + 772, 1, F_VS, 1, "b_mid_vs");
    exp_reset(R0 + 773, 1, 0, "b_midrst");
    expect_at(R0 + 774, 1, F_TICK, 1, "b_first_tick");
    expect_at(R0 + 775, 1, F_H,    1, "b_first_step_h");
    goto(R0 + 772);
    rst_b = 1'b1;
    goto(R0 + 773);
    rst_b = 1'b0;
    done_b = 1'b1;
  end

  initial begin : main
    exp_t e;
    for (int i = 0; i < 25000 && !(done_a && done_b && sbq.size() == 0); i++) @(posedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL %s: actual=not reached required=check at cycle %0d", e.name, e.at);
    end
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL provide parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 The block SHALL provide parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels; line total 800.
REQ-003 The block SHALL provide parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 The block SHALL provide parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, in lines; frame total 525.
REQ-005 The block SHALL provide parameter CLK_DIV, default 2, clk cycles per pixel (legal range 1..16).
REQ-006 The block SHALL provide parameter SYNC_ACTIVE, default 0, asserted level of hsync/vsync.
REQ-007 The block SHALL have port clk, input, 1 bit, system clock; reset rst, synchronous, active-high.
REQ-008 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 The block SHALL have port en, input, 1 bit, run enable; low freezes all state.
REQ-010 The block SHALL have port pix_tick, output, 1 bit, one-clk pulse per pixel period.
REQ-011 The block SHALL have port hcount, output, 10 bits, current pixel column 0..799.
REQ-012 The block SHALL have port vcount, output, 10 bits, current line 0..524.
REQ-013 The block SHALL have ports hsync and vsync, outputs, 1 bit each, sync strobes at SYNC_ACTIVE level.
REQ-014 The block SHALL have port video_on, output, 1 bit, high when (hcount,vcount) is in the visible area.
REQ-015 The block SHALL have ports line_start and frame_start, outputs, 1 bit each, one-clk pulses.

Function
REQ-016 Divider counter 0..CLK_DIV-1 SHALL advance each clk while en=1; pix_tick=1 in the cycle the divider equals CLK_DIV-1; with CLK_DIV=1, pix_tick=en.
REQ-017 On each clk edge where pix_tick=1, hcount SHALL increment by 1; at 799 it SHALL wrap to 0.
REQ-018 vcount SHALL increment only on the pix_tick edge where hcount wraps; at 524 it SHALL wrap to 0 in the same edge.
REQ-019 Horizontal phase FSM SHALL have states H_VIS (0..639), H_FP (640..655), H_SYNC (656..751), H_BP (752..799); transitions occur on the same edge that hcount crosses each boundary.
REQ-020 Vertical phase FSM SHALL have states V_VIS (0..479), V_FP (480..489), V_SYNC (490..491), V_BP (492..524); transitions occur with vcount.
REQ-021 hsync SHALL equal SYNC_ACTIVE exactly when the H FSM is in H_SYNC; vsync likewise for V_SYNC; both registered and cycle-aligned with hcount/vcount (zero skew).
REQ-022 video_on SHALL be registered and equal (H_VIS and V_VIS) in the same cycle as the counts.
REQ-023 line_start SHALL pulse for one clk in the cycle after hcount becomes 0; frame_start SHALL pulse in the same cycle when vcount is also 0.
REQ-024 When en=0, divider, counters, FSMs and level outputs SHALL hold; pix_tick, line_start and frame_start SHALL be 0.
REQ-025 Phase boundaries SHALL be derived from parameters only; all comparisons are unsigned 10-bit.

Reset
REQ-026 On rst=1 at a clk edge: divider=0, hcount=0, vcount=0, H_VIS, V_VIS, video_on=1, hsync=vsync=!SYNC_ACTIVE, pix_tick=line_start=frame_start=0.
REQ-027 rst SHALL take priority over en and over a coincident pix_tick; reset mid-frame restarts at (0,0) with no partial sync pulse.
REQ-028 The first pix_tick after reset release with en=1 SHALL occur CLK_DIV clk cycles later.

Structure
REQ-029 Package vga_pkg SHALL hold the 640x480@60 timing constants, derived totals (H_TOTAL=800, V_TOTAL=525), and enums h_phase_t / v_phase_t.
REQ-030 Divider SHALL be a sub-module pixel_tick_gen (clk, rst, en -> pix_tick); counters and FSMs remain in vga_timing_gen.

Verification
REQ-031 Reset: assert rst 3 cycles -> hcount=0, vcount=0, video_on=1, hsync=vsync=1, all pulses 0.
REQ-032 Line wrap: run to hcount=799, vcount=10, next pix_tick -> hcount=0, vcount=11, line_start=1 for exactly one clk, frame_start=0.
REQ-033 Hsync width: over one line, hsync low for exactly 96 pix_ticks beginning at hcount=656; video_on low from hcount=640 to 799.
REQ-034 Frame wrap: at (799,524) next pix_tick -> (0,0), frame_start=1 and line_start=1 one clk; full frame = 840000 clk at CLK_DIV=2; vsync low for lines 490-491 only.
REQ-035 Enable: drop en at hcount=300 for 50 clk -> hcount stays 300, no pix_tick; resume continues at 301.
REQ-036 Mid-frame reset: rst at (400,200) in H_SYNC-free region and at (700,491) during sync -> outputs return to reset values next edge, hsync/vsync deassert immediately.
